// File: rtl/decodificador_seq_if.sv
// Bus between the code producer / one-hot consumer and the sequential decoder.
interface decodificador_seq_if #(
  parameter int W = 3
) ();
  localparam int N = 1 << W;

  logic [W-1:0] i;
  logic         g;
  logic         ack;
  logic [N-1:0] o;
  logic         v;
  logic [N-1:0] pend;
  logic         ovf;

  modport master (output i, g, ack, input  o, v, pend, ovf);
  modport slave  (input  i, g, ack, output o, v, pend, ovf);
endinterface

// File: rtl/decodificador_seq.sv
// Sequential N-to-2^N decoder: captures codes into a pending mask and
// presents the highest pending request as a registered one-hot word with
// a valid/ack handshake.

// One pending-request bit. Set has priority over clear so a code that
// arrives on the same edge as its ack is not lost.
module decodificador_seq_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);
  // pending bit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

module decodificador_seq #(
  parameter int W = 3
) (
  input  logic               clk,
  input  logic               rst,
  decodificador_seq_if.slave bus
);
  localparam int N = 1 << W;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pend;
  logic [N-1:0] dec_i;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] o_q, o_nxt;
  logic         v_q, v_nxt;
  logic         ovf_q;
  logic [W-1:0] k;
  logic         any_pend;

  // one-hot image of the incoming code, gated by its valid
  always_comb begin
    dec_i = '0;
    for (int b = 0; b < N; b++) dec_i[b] = (bus.i == W'(b));
    set_vec = bus.g ? dec_i : '0;
  end

  // highest set index of the registered mask; later iterations win
  always_comb begin
    k        = '0;
    any_pend = |pend;
    for (int b = 0; b < N; b++) if (pend[b]) k = W'(b);
  end

  genvar gb;
  generate
    for (gb = 0; gb < N; gb++) begin : g_cell
      decodificador_seq_cell u_cell (
        .clk (clk),
        .rst (rst),
        .set (set_vec[gb]),
        .clr (clr_vec[gb]),
        .q   (pend[gb])
      );
    end
  endgenerate

  // state and presented-word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      o_q   <= '0;
      v_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      o_q   <= o_nxt;
      v_q   <= v_nxt;
    end
  end

  // next state, next word and the pending-bit release on ack
  always_comb begin
    state_nxt = state;
    o_nxt     = o_q;
    v_nxt     = v_q;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        o_nxt = '0;
        v_nxt = 1'b0;
        if (any_pend) begin
          o_nxt     = N'(1) << k;
          v_nxt     = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          clr_vec   = o_q;
          o_nxt     = '0;
          v_nxt     = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        o_nxt     = '0;
        v_nxt     = 1'b0;
      end
    endcase
  end

  // sticky duplicate flag: a code hit a bit that was already pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      ovf_q <= 1'b0;
    else if (|(set_vec & pend))   ovf_q <= 1'b1;
  end

  assign bus.o    = o_q;
  assign bus.v    = v_q;
  assign bus.pend = pend;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_decodificador_seq.sv
// Directed bench for decodificador_seq: vector table for single request and
// burst ordering, hand sequences for hold, duplicate/set-wins and reset.
module tb_decodificador_seq;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decodificador_seq_if #(.W(W)) bus ();
  decodificador_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       g;
    logic [2:0] i;
    logic       ack;
    logic [7:0] o;
    logic       v;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic g, logic [2:0] i, logic ack,
                              logic [7:0] o, logic v, logic [7:0] pend, logic ovf);
    vec_t r;
    r.g = g; r.i = i; r.ack = ack; r.o = o; r.v = v; r.pend = pend; r.ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // o is one-hot-or-zero and nonzero exactly when v
  task automatic inv();
    chk("onehot", {31'd0, $onehot0(bus.o)}, 32'd1);
    chk("o_vs_v", {31'd0, (bus.o != 8'h00)}, {31'd0, bus.v});
  endtask

  task automatic step(input logic g, input logic [2:0] i, input logic ack);
    @(negedge clk);
    bus.g = g; bus.i = i; bus.ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single request (rows 0-3), burst 4,6,5,0 with ack held high (rows 4-13)
    tbl[0]  = mk(1, 3'd4, 0, 8'h00, 0, 8'h10, 0);
    tbl[1]  = mk(0, 3'd0, 0, 8'h10, 1, 8'h10, 0);
    tbl[2]  = mk(0, 3'd0, 1, 8'h00, 0, 8'h00, 0);
    tbl[3]  = mk(0, 3'd0, 0, 8'h00, 0, 8'h00, 0);
    tbl[4]  = mk(1, 3'd4, 1, 8'h00, 0, 8'h10, 0);
    tbl[5]  = mk(1, 3'd6, 1, 8'h10, 1, 8'h50, 0);
    tbl[6]  = mk(1, 3'd5, 1, 8'h00, 0, 8'h60, 0);
    tbl[7]  = mk(1, 3'd0, 1, 8'h40, 1, 8'h61, 0);
    tbl[8]  = mk(0, 3'd0, 1, 8'h00, 0, 8'h21, 0);
    tbl[9]  = mk(0, 3'd0, 1, 8'h20, 1, 8'h21, 0);
    tbl[10] = mk(0, 3'd0, 1, 8'h00, 0, 8'h01, 0);
    tbl[11] = mk(0, 3'd0, 1, 8'h01, 1, 8'h01, 0);
    tbl[12] = mk(0, 3'd0, 1, 8'h00, 0, 8'h00, 0);
    tbl[13] = mk(0, 3'd0, 0, 8'h00, 0, 8'h00, 0);

    bus.g = 1'b0; bus.i = '0; bus.ack = 1'b0;
    #1;
    chk("rst_o", bus.o, 0); chk("rst_v", bus.v, 0);
    chk("rst_pend", bus.pend, 0); chk("rst_ovf", bus.ovf, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // idle robustness: g low, random code and ack
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 3'($urandom_range(7)), 1'($urandom_range(1)));
      chk("idle_ovp", {bus.o, bus.v, bus.pend, bus.ovf}, 0);
    end

    for (int n = 0; n < 14; n++) begin
      step(tbl[n].g, tbl[n].i, tbl[n].ack);
      chk($sformatf("vec%0d", n), {bus.o, bus.v, bus.pend, bus.ovf},
          {tbl[n].o, tbl[n].v, tbl[n].pend, tbl[n].ovf});
      inv();
    end

    // hold without ack while a higher code arrives
    step(1'b1, 3'd3, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    chk("hold_first", {bus.o, bus.v}, {8'h08, 1'b1});
    for (int n = 0; n < 10; n++) begin
      step(n == 2, 3'd7, 1'b0);
      chk("hold_o", {bus.o, bus.v}, {8'h08, 1'b1});
    end
    chk("hold_pend", bus.pend, 8'h88);
    step(1'b0, 3'd0, 1'b1);
    chk("hold_rel", {bus.o, bus.v, bus.pend}, {8'h00, 1'b0, 8'h80});
    step(1'b0, 3'd0, 1'b0);
    chk("hold_next", {bus.o, bus.v}, {8'h80, 1'b1});
    step(1'b0, 3'd0, 1'b1);
    chk("hold_done", {bus.o, bus.v, bus.pend, bus.ovf}, 0);

    // duplicate sets ovf, set wins over ack of the same index
    step(1'b1, 3'd2, 1'b0);
    chk("dup_first", {bus.pend, bus.ovf}, {8'h04, 1'b0});
    step(1'b1, 3'd2, 1'b0);
    chk("dup_ovf", {bus.o, bus.v, bus.pend, bus.ovf}, {8'h04, 1'b1, 8'h04, 1'b1});
    step(1'b1, 3'd2, 1'b1);
    chk("setwin", {bus.o, bus.v, bus.pend, bus.ovf}, {8'h00, 1'b0, 8'h04, 1'b1});
    step(1'b0, 3'd0, 1'b0);
    chk("represent", {bus.o, bus.v}, {8'h04, 1'b1});
    inv();

    // asynchronous reset mid-cycle, no edge needed
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_all", {bus.o, bus.v, bus.pend, bus.ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.g = 1'b0; bus.ack = 1'b0;

    // reset while presenting with pend = 8'h24
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    chk("pre_rst", {bus.o, bus.v, bus.pend}, {8'h20, 1'b1, 8'h24});
    @(negedge clk);
    bus.g = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("prst_all", {bus.o, bus.v, bus.pend, bus.ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 3'd0, 1'b0);
      chk("prst_quiet", {bus.o, bus.v, bus.pend, bus.ovf}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
